// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seq_divider : restoring radix-2 sequential divider, signed/unsigned, full/half
// Revision    : 1.0
// ============================================================================
module seq_divider #(
  parameter int W = 16
) (
  input  logic           iClk,
  input  logic           iRstN,
  input  logic           iStall,
  input  logic           iReq,
  input  logic           iSgn,
  input  logic           iHalf,
  input  logic [2*W-1:0] iNumer,
  input  logic [W-1:0]   iDenom,
  output logic [W-1:0]   oQuotient,
  output logic [W-1:0]   oRemain,
  output logic           oAck,
  output logic [1:0]     oErr,
  output logic           oBusy
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DZ   = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  localparam logic [CW-1:0] LAST_F = CW'(W - 1);
  localparam logic [CW-1:0] LAST_H = CW'(H - 1);
  localparam logic [W-1:0]  LIM_F  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  LIM_H  = {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [W-1:0]   rem_q,   rem_d;
  logic [W-1:0]   dq_q,    dq_d;
  logic [W-1:0]   den_q,   den_d;
  logic [2*W-1:0] raw_q,   raw_d;
  logic           nsign_q, nsign_d;
  logic           rsign_q, rsign_d;
  logic           half_q,  half_d;
  logic           sgn_q,   sgn_d;
  logic           dz_q,    dz_d;
  logic           ovf_q,   ovf_d;
  logic           ack_q,   ack_d;
  logic [W-1:0]   quot_q,  quot_d;
  logic [W-1:0]   remo_q,  remo_d;
  logic [1:0]     err_q,   err_d;

  // Operand conditioning at accept time
  logic           w_nsign;
  logic           w_dsign;
  logic [2*W-1:0] w_numf_mag;
  logic [W-1:0]   w_numh_mag;
  logic [W-1:0]   w_denf_mag;
  logic [H-1:0]   w_denh_mag;
  logic [W-1:0]   w_rem_init;
  logic [W-1:0]   w_dq_init;
  logic [W-1:0]   w_den_init;
  logic           w_dz;
  logic           w_ovf;

  always_comb begin
    w_nsign    = iSgn & (iHalf ? iNumer[W-1] : iNumer[2*W-1]);
    w_dsign    = iSgn & (iHalf ? iDenom[H-1] : iDenom[W-1]);
    w_numf_mag = w_nsign ? -iNumer : iNumer;
    w_numh_mag = w_nsign ? -iNumer[W-1:0] : iNumer[W-1:0];
    w_denf_mag = w_dsign ? -iDenom : iDenom;
    w_denh_mag = w_dsign ? -iDenom[H-1:0] : iDenom[H-1:0];
    // Half mode reuses the full datapath: upper numerator half seeds the
    // partial remainder, lower half is left-aligned in the shift register.
    if (iHalf) begin
      w_rem_init = {{H{1'b0}}, w_numh_mag[W-1:H]};
      w_dq_init  = {w_numh_mag[H-1:0], {H{1'b0}}};
      w_den_init = {{H{1'b0}}, w_denh_mag};
    end else begin
      w_rem_init = w_numf_mag[2*W-1:W];
      w_dq_init  = w_numf_mag[W-1:0];
      w_den_init = w_denf_mag;
    end
    w_dz  = iHalf ? (iDenom[H-1:0] == '0) : (iDenom == '0);
    // Quotient cannot fit the active width when the seed already reaches the divisor
    w_ovf = ~w_dz & (w_rem_init >= w_den_init);
  end

  // One restoring step; dq_q shifts dividend bits out the top, quotient bits in the bottom
  logic [W:0]   w_trial;
  logic         w_ge;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_rem_step;
  logic [W-1:0] w_dq_step;

  always_comb begin
    w_trial    = {rem_q, dq_q[W-1]};
    w_ge       = (w_trial >= {1'b0, den_q});
    w_diff     = w_trial[W-1:0] - den_q;
    w_rem_step = w_ge ? w_diff : w_trial[W-1:0];
    w_dq_step  = {dq_q[W-2:0], w_ge};
  end

  // Result formatting applied on the final step
  logic [W-1:0]  w_qmag;
  logic [W-1:0]  w_qneg;
  logic [W-1:0]  w_rneg;
  logic [W-1:0]  w_qres;
  logic [W-1:0]  w_rres;
  logic [W-1:0]  w_lim;
  logic          w_sovf;
  logic [1:0]    w_err;
  logic [CW-1:0] w_last;

  always_comb begin
    w_qmag = half_q ? {{H{1'b0}}, w_dq_step[H-1:0]} : w_dq_step;
    w_lim  = half_q ? LIM_H : LIM_F;
    w_sovf = sgn_q & ((w_qmag > w_lim) | ((w_qmag == w_lim) & ~rsign_q));
    w_qneg = rsign_q ? -w_qmag : w_qmag;
    w_rneg = nsign_q ? -w_rem_step : w_rem_step;
    w_qres = half_q ? {{H{1'b0}}, w_qneg[H-1:0]} : w_qneg;
    w_rres = half_q ? {{H{1'b0}}, w_rneg[H-1:0]} : w_rneg;
    w_err  = dz_q ? ERR_DZ : ((ovf_q | w_sovf) ? ERR_OVF : ERR_NONE);
    w_last = half_q ? LAST_H : LAST_F;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    den_d   = den_q;
    raw_d   = raw_q;
    nsign_d = nsign_q;
    rsign_d = rsign_q;
    half_d  = half_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    ack_d   = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (iReq && !iStall) begin
          state_d = S_ITER;
          cnt_d   = '0;
          rem_d   = w_rem_init;
          dq_d    = w_dq_init;
          den_d   = w_den_init;
          raw_d   = iNumer;
          nsign_d = w_nsign;
          rsign_d = w_nsign ^ w_dsign;
          half_d  = iHalf;
          sgn_d   = iSgn;
          dz_d    = w_dz;
          ovf_d   = w_ovf;
        end
      end
      S_ITER: begin
        rem_d = w_rem_step;
        dq_d  = w_dq_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == w_last) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          err_d   = w_err;
          if (w_err != ERR_NONE) begin
            quot_d = raw_q[W-1:0];
            remo_d = raw_q[2*W-1:W];
          end else begin
            quot_d = w_qres;
            remo_d = w_rres;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      den_q   <= '0;
      raw_q   <= '0;
      nsign_q <= 1'b0;
      rsign_q <= 1'b0;
      half_q  <= 1'b0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      den_q   <= den_d;
      raw_q   <= raw_d;
      nsign_q <= nsign_d;
      rsign_q <= rsign_d;
      half_q  <= half_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      err_q   <= err_d;
    end
  end

  assign oQuotient = quot_q;
  assign oRemain   = remo_q;
  assign oErr      = err_q;
  assign oAck      = ack_q;
  assign oBusy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
